// File: rtl/multicycle_sequencer.sv
// Step sequencer for a multicycle core: walks each instruction through its
// steps, arbitrates the memory port, and handles halt and memory timeouts.
module multicycle_sequencer #(
    parameter int CNT_W   = 3,
    parameter int TIMEOUT = 15,
    parameter int RET_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       InsM,
    input  logic [1:0]       InsL,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] Cnt,
    output logic             Buff_PC,
    output logic             MEMresource,
    output logic             mem_req,
    output logic             halted,
    output logic             mem_err,
    output logic             illegal,
    output logic [RET_W-1:0] ret_cnt
);

    typedef enum logic [1:0] {
        S_RUN,
        S_HALT,
        S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        K_LOAD,
        K_STORE,
        K_ALU,
        K_BR,
        K_HLT,
        K_ILL
    } kind_t;

    state_t           state;
    state_t           state_n;
    kind_t            kind;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] last;
    logic [7:0]       wait_cnt;
    logic [7:0]       wait_n;
    logic [RET_W-1:0] ret_n;
    logic [6:0]       ir;
    logic [4:0]       op;
    logic [1:0]       fn;
    logic             run;
    logic             is_ls;
    logic             at_zero;
    logic             at_three;
    logic             waiting;
    logic             timeout;
    logic             fetch_done;
    logic             halt_go;

    assign op = ir[6:2];
    assign fn = ir[1:0];

    // Instruction class from the latched fetch word
    always_comb begin
        kind = K_ILL;
        unique case (1'b1)
            op == 5'b00011,
            op == 5'b00100 && fn == 2'b00: kind = K_LOAD;
            op == 5'b00101,
            op == 5'b00110 && fn == 2'b00: kind = K_STORE;
            op == 5'b00000,
            op == 5'b00110 && fn == 2'b01,
            op == 5'b00001,
            op == 5'b00010,
            op == 5'b00111,
            op == 5'b01000,
            op == 5'b01011,
            op == 5'b10001,
            op == 5'b10010: kind = K_ALU;
            op == 5'b11000,
            op == 5'b11001,
            op == 5'b10000,
            op == 5'b10011,
            op == 5'b11100 && fn == 2'b00: kind = K_BR;
            op == 5'b11100 && fn == 2'b01: kind = K_HLT;
            default: kind = K_ILL;
        endcase
    end

    always_comb begin
        last = CNT_W'(3);
        unique case (kind)
            K_LOAD:       last = CNT_W'(4);
            K_BR:         last = CNT_W'(2);
            K_HLT, K_ILL: last = CNT_W'(1);
            default:      last = CNT_W'(3);
        endcase
    end

    assign run        = state == S_RUN;
    assign is_ls      = kind inside {K_LOAD, K_STORE};
    assign at_zero    = Cnt == '0;
    assign at_three   = Cnt == CNT_W'(3);
    assign mem_req    = run && (at_zero || (is_ls && at_three));
    assign MEMresource = run && is_ls && at_three;
    assign waiting    = mem_req && !mem_ready;
    assign timeout    = waiting && wait_cnt == 8'(TIMEOUT - 1);
    assign fetch_done = run && at_zero && mem_ready;
    assign halt_go    = run && kind == K_HLT && Cnt == CNT_W'(1);
    assign illegal    = run && kind == K_ILL && Cnt == CNT_W'(1);
    assign halted     = state == S_HALT;
    assign mem_err    = state == S_ERROR;

    // Reset suppresses retirement so an aborted instruction never counts
    assign Buff_PC = run && !rst && kind != K_HLT && !at_zero
                  && Cnt == last && !waiting;

    always_comb begin
        state_n = state;
        cnt_n   = Cnt;
        wait_n  = '0;
        ret_n   = ret_cnt;
        unique case (state)
            S_RUN: begin
                if (timeout) begin
                    state_n = S_ERROR;
                    cnt_n   = '0;
                end else if (waiting) begin
                    wait_n = wait_cnt + 8'd1;
                end else if (halt_go) begin
                    state_n = S_HALT;
                    cnt_n   = '0;
                    ret_n   = ret_cnt + RET_W'(1);
                end else if (Buff_PC) begin
                    cnt_n = '0;
                    ret_n = ret_cnt + RET_W'(1);
                end else begin
                    cnt_n = Cnt + CNT_W'(1);
                end
            end
            default: cnt_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RUN;
            Cnt      <= '0;
            wait_cnt <= '0;
            ret_cnt  <= '0;
            ir       <= '0;
        end else begin
            state    <= state_n;
            Cnt      <= cnt_n;
            wait_cnt <= wait_n;
            ret_cnt  <= ret_n;
            if (fetch_done) begin
                ir <= {InsM, InsL};
            end
        end
    end

endmodule
